// File: rtl/mii_net_pkg.sv
// Shared definitions for the MII receive path: FSM states, framing nibbles
// and the reflected CRC-32 byte step used by RX checking and TX FCS generation.
package mii_net_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    HOLD,
    DROP
  } rx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // One byte of the LSB-first CRC-32, unrolled bit by bit.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected Ethernet CRC-32 accumulator. The register is not inverted,
// so after a frame including its FCS it holds the residue.
import mii_net_pkg::*;

module eth_crc32 (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_crc <= 32'hFFFFFFFF;
    end else if (i_init) begin
      r_crc <= 32'hFFFFFFFF;
    end else if (i_en) begin
      r_crc <= crc32_byte(r_crc, i_byte);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into buffer writes,
// checks FCS and length, and holds one completed frame until acknowledged.
import mii_net_pkg::*;

module mii_rx_deframer #(
  parameter int ADDR_W  = 10,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              i_clk,
  input  logic              i_nreset,
  input  logic              enet_rx_dv,
  input  logic              enet_rx_er,
  input  logic [3:0]        enet_rx_data,
  input  logic              i_enable,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_frame_valid,
  output logic [15:0]       o_frame_len,
  output logic              o_crc_ok,
  output logic              o_len_err,
  input  logic              i_frame_ack,
  output logic [15:0]       o_drop_count
);

  // ADDR_W is limited to 16 so byte addresses fit in the 16-bit length counter.
  localparam logic [16:0] BUF_BYTES = 17'(1) << ADDR_W;

  rx_state_t r_state;
  rx_state_t w_next;

  logic              r_phase;
  logic [3:0]        r_low;
  logic [15:0]       r_count;
  logic              r_ovf;
  logic              r_dv_d;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [15:0]       r_len;
  logic              r_crc_ok;
  logic              r_len_err;
  logic [15:0]       r_drops;

  logic              w_start;
  logic              w_byte;
  logic              w_latch;
  logic              w_drop_evt;
  logic [7:0]        w_byte_val;
  logic [31:0]       w_crc;

  assign w_byte_val = {enet_rx_data, r_low};

  eth_crc32 u_crc (
    .i_clk    (i_clk),
    .i_nreset (i_nreset),
    .i_init   (w_start),
    .i_en     (w_byte),
    .i_byte   (w_byte_val),
    .o_crc    (w_crc)
  );

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (enet_rx_dv) begin
          w_next = (i_enable && !o_frame_valid) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!enet_rx_dv) begin
          w_next = IDLE;
        end else if (enet_rx_data == SFD_NIB) begin
          w_next = DATA;
        end else if (enet_rx_data != PREAMBLE_NIB) begin
          w_next = DROP;
        end
      end
      DATA: begin
        if (!enet_rx_dv) begin
          w_next = r_phase ? IDLE : HOLD;
        end else if (enet_rx_er) begin
          w_next = DROP;
        end
      end
      HOLD: begin
        if (i_frame_ack) begin
          w_next = enet_rx_dv ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!enet_rx_dv) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A dv rise while a frame is held is the start of a frame that will be lost.
  always_comb begin
    w_start    = 1'b0;
    w_byte     = 1'b0;
    w_latch    = 1'b0;
    w_drop_evt = 1'b0;
    case (r_state)
      IDLE: begin
        w_drop_evt = enet_rx_dv && !(i_enable && !o_frame_valid);
      end
      PRE: begin
        w_start    = enet_rx_dv && (enet_rx_data == SFD_NIB);
        w_drop_evt = enet_rx_dv && (enet_rx_data != SFD_NIB) &&
                     (enet_rx_data != PREAMBLE_NIB);
      end
      DATA: begin
        if (!enet_rx_dv) begin
          w_latch    = !r_phase;
          w_drop_evt = r_phase;
        end else if (enet_rx_er) begin
          w_drop_evt = 1'b1;
        end else begin
          w_byte = r_phase;
        end
      end
      HOLD: begin
        w_drop_evt = enet_rx_dv && !r_dv_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_phase   <= 1'b0;
      r_low     <= 4'h0;
      r_count   <= 16'h0;
      r_ovf     <= 1'b0;
      r_dv_d    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h0;
      r_len     <= 16'h0;
      r_crc_ok  <= 1'b0;
      r_len_err <= 1'b0;
      r_drops   <= 16'h0;
    end else begin
      r_dv_d  <= enet_rx_dv;
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_phase <= 1'b0;
        r_count <= 16'h0;
        r_ovf   <= 1'b0;
      end else if (r_state == DATA && enet_rx_dv && !enet_rx_er) begin
        r_phase <= !r_phase;
        if (!r_phase) begin
          r_low <= enet_rx_data;
        end
      end
      if (w_byte) begin
        if (r_count != 16'hFFFF) begin
          r_count <= r_count + 16'd1;
        end
        if ({1'b0, r_count} < BUF_BYTES) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_count[ADDR_W-1:0];
          r_wr_data <= w_byte_val;
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if (w_latch) begin
        r_len     <= r_count;
        r_crc_ok  <= (w_crc == CRC32_RESIDUE);
        r_len_err <= r_ovf || (r_count < 16'(MIN_LEN)) || (r_count > 16'(MAX_LEN));
      end
      if (w_drop_evt && r_drops != 16'hFFFF) begin
        r_drops <= r_drops + 16'd1;
      end
    end
  end

  assign o_frame_valid = (r_state == HOLD);
  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_frame_len   = r_len;
  assign o_crc_ok      = o_frame_valid && r_crc_ok;
  assign o_len_err     = o_frame_valid && r_len_err;
  assign o_drop_count  = r_drops;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed bench for mii_rx_deframer: frames are built with a locally computed
// FCS, expected writes and frame results are queued and checked as they appear.
module tb_mii_rx_deframer;

  typedef struct packed {
    logic [15:0] len;
    logic        crc;
    logic        lerr;
  } fexp_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic [3:0]  nib = 4'h0;
  logic        enable = 1'b0;
  logic        ack = 1'b0;

  logic        wrEn, fValid, crcOk, lenErr;
  logic [9:0]  wrAddr;
  logic [7:0]  wrData;
  logic [15:0] fLen, drops;

  logic        wrEn2, fValid2, crcOk2, lenErr2;
  logic [5:0]  wrAddr2;
  logic [7:0]  wrData2;
  logic [15:0] fLen2, drops2;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  frm[$];
  logic [17:0] wrQ[$];
  fexp_t       frmQ[$];
  bit          skipWrites = 1'b0;
  bit          prevValid = 1'b0;
  int          w2Cnt = 0;
  int          w2Max = 0;

  mii_rx_deframer #(.ADDR_W(10)) dut (
    .i_clk(clk), .i_nreset(nreset), .enet_rx_dv(dv), .enet_rx_er(er),
    .enet_rx_data(nib), .i_enable(enable), .o_wr_en(wrEn), .o_wr_addr(wrAddr),
    .o_wr_data(wrData), .o_frame_valid(fValid), .o_frame_len(fLen),
    .o_crc_ok(crcOk), .o_len_err(lenErr), .i_frame_ack(ack),
    .o_drop_count(drops)
  );

  mii_rx_deframer #(.ADDR_W(6)) dutSmall (
    .i_clk(clk), .i_nreset(nreset), .enet_rx_dv(dv), .enet_rx_er(er),
    .enet_rx_data(nib), .i_enable(enable), .o_wr_en(wrEn2), .o_wr_addr(wrAddr2),
    .o_wr_data(wrData2), .o_frame_valid(fValid2), .o_frame_len(fLen2),
    .o_crc_ok(crcOk2), .o_len_err(lenErr2), .i_frame_ack(ack),
    .o_drop_count(drops2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void buildFrame(input int n);
    logic [7:0] hdr[$];
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h06,
            8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h0A,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
    frm.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 42) frm.push_back(hdr[i]);
      else if (n == 60) frm.push_back(8'h00);
      else frm.push_back(8'(i * 7));
    end
  endfunction

  function automatic void appendFcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endfunction

  task automatic driveNib(input logic d, input logic e, input logic [3:0] n, input logic a);
    @(posedge clk);
    #1;
    dv = d; er = e; nib = n; ack = a;
  endtask

  task automatic applyStimulus(input int pushN, input bit oddNib, input int erAt, input int ackAt);
    logic [7:0] b;
    for (int i = 0; i < pushN; i++) begin
      if (i < 1024) wrQ.push_back({10'(i), frm[i]});
    end
    repeat (3) driveNib(1'b0, 1'b0, 4'h0, 1'b0);
    repeat (15) driveNib(1'b1, 1'b0, 4'h5, 1'b0);
    driveNib(1'b1, 1'b0, 4'hD, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      driveNib(1'b1, i == erAt, b[3:0], i == ackAt);
      driveNib(1'b1, 1'b0, b[7:4], 1'b0);
    end
    if (oddNib) driveNib(1'b1, 1'b0, 4'hA, 1'b0);
    driveNib(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!fValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("valid_latency", n, 2);
  endtask

  task automatic ackFrame();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    checkOutput("valid_after_ack", fValid, 0);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [17:0] ew;
    fexp_t ef;
    if (nreset && !skipWrites && wrEn) begin
      if (wrQ.size() == 0) checkOutput("write_unexpected", 1, 0);
      else begin
        ew = wrQ.pop_front();
        checkOutput("write_addr_data", {14'h0, wrAddr, wrData}, {14'h0, ew});
      end
    end
    if (wrEn2) begin
      w2Cnt++;
      if (int'(wrAddr2) > w2Max) w2Max = int'(wrAddr2);
    end
    if (fValid && !prevValid) begin
      if (frmQ.size() == 0) checkOutput("valid_unexpected", 1, 0);
      else begin
        ef = frmQ.pop_front();
        checkOutput("frame_len", fLen, ef.len);
        checkOutput("crc_ok", crcOk, ef.crc);
        checkOutput("len_err", lenErr, ef.lerr);
      end
    end
    prevValid = fValid;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] b;
    // Reset state
    #12;
    checkOutput("rst_wr_en", wrEn, 0);
    checkOutput("rst_valid", fValid, 0);
    checkOutput("rst_drops", drops, 0);
    checkOutput("rst_len", fLen, 0);
    @(posedge clk); #1 nreset = 1'b1; enable = 1'b1;

    // Good 64-byte ARP frame
    buildFrame(60); appendFcs();
    frmQ.push_back('{len: 16'd64, crc: 1'b1, lerr: 1'b0});
    applyStimulus(64, 1'b0, -1, -1);
    waitValid();
    checkOutput("t1_drops", drops, 0);
    ackFrame();

    // Corrupted payload nibble
    buildFrame(60); appendFcs();
    frm[20] = frm[20] ^ 8'h10;
    frmQ.push_back('{len: 16'd64, crc: 1'b0, lerr: 1'b0});
    applyStimulus(64, 1'b0, -1, -1);
    waitValid();
    checkOutput("t2_drops", drops, 0);
    ackFrame();

    // Odd nibble count, then rx_er mid-frame
    buildFrame(60); appendFcs();
    applyStimulus(64, 1'b1, -1, -1);
    settle();
    checkOutput("t3_odd_valid", fValid, 0);
    checkOutput("t3_odd_drops", drops, 1);
    applyStimulus(10, 1'b0, 10, -1);
    settle();
    checkOutput("t3_er_valid", fValid, 0);
    checkOutput("t3_er_drops", drops, 2);

    // Frames arriving while one is held, ack mid-frame
    frmQ.push_back('{len: 16'd64, crc: 1'b1, lerr: 1'b0});
    applyStimulus(64, 1'b0, -1, -1);
    waitValid();
    applyStimulus(0, 1'b0, -1, -1);
    settle();
    checkOutput("t4_still_held", fValid, 1);
    checkOutput("t4_drops_held", drops, 3);
    applyStimulus(0, 1'b0, -1, 5);
    settle();
    checkOutput("t4_valid_after_midack", fValid, 0);
    checkOutput("t4_drops_midack", drops, 4);
    frmQ.push_back('{len: 16'd64, crc: 1'b1, lerr: 1'b0});
    applyStimulus(64, 1'b0, -1, -1);
    waitValid();
    ackFrame();

    // Runt frame
    buildFrame(16); appendFcs();
    frmQ.push_back('{len: 16'd20, crc: 1'b1, lerr: 1'b1});
    applyStimulus(20, 1'b0, -1, -1);
    waitValid();
    ackFrame();

    // 100-byte frame: fits the 1 KiB buffer, overflows the 64-byte one
    buildFrame(96); appendFcs();
    w2Cnt = 0; w2Max = 0;
    frmQ.push_back('{len: 16'd100, crc: 1'b1, lerr: 1'b0});
    applyStimulus(100, 1'b0, -1, -1);
    waitValid();
    checkOutput("t5_small_valid", fValid2, 1);
    checkOutput("t5_small_len", fLen2, 100);
    checkOutput("t5_small_len_err", lenErr2, 1);
    checkOutput("t5_small_crc_ok", crcOk2, 1);
    checkOutput("t5_small_writes", w2Cnt, 64);
    checkOutput("t5_small_max_addr", w2Max, 63);
    ackFrame();

    // Reset mid-DATA
    buildFrame(60); appendFcs();
    skipWrites = 1'b1;
    repeat (15) driveNib(1'b1, 1'b0, 4'h5, 1'b0);
    driveNib(1'b1, 1'b0, 4'hD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      b = frm[i];
      driveNib(1'b1, 1'b0, b[3:0], 1'b0);
      driveNib(1'b1, 1'b0, b[7:4], 1'b0);
    end
    @(posedge clk); #2 nreset = 1'b0;
    #1;
    checkOutput("t6_wr_en", wrEn, 0);
    checkOutput("t6_wr_addr", wrAddr, 0);
    checkOutput("t6_valid", fValid, 0);
    checkOutput("t6_drops", drops, 0);
    checkOutput("t6_len", fLen, 0);
    checkOutput("t6_crc_ok", crcOk, 0);
    checkOutput("t6_len_err", lenErr, 0);
    dv = 1'b0;
    @(posedge clk); #1 nreset = 1'b1;
    @(negedge clk);
    skipWrites = 1'b0;
    frmQ.push_back('{len: 16'd64, crc: 1'b1, lerr: 1'b0});
    applyStimulus(64, 1'b0, -1, -1);
    waitValid();
    checkOutput("t6_drops_after", drops, 0);
    ackFrame();

    settle();
    checkOutput("writes_outstanding", wrQ.size(), 0);
    checkOutput("frames_outstanding", frmQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
